oled_mode_switcher: RTL and testbench

Parametrised N-channel I2C bus switcher between the OLED display-page generators (one per screen mode) and the single OLED I2C pin pair. Only one generator owns the bus at a time. Mode changes happen only at a transaction boundary, followed by a released-bus guard gap and a forced redraw of the new page. Unlike a plain combinational mux, it never cuts a transfer mid-byte, times out a stuck generator, and ignores out-of-range modes.

---
 rtl/oled_mode_switcher.sv | 127 ++++++++++++
 tb/tb_oled_mode_switcher.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/oled_mode_switcher.sv
// oled_mode_switcher: hands the OLED I2C pins to one page generator at a time, switching only between transactions
module oled_mode_switcher #(
    parameter int          N_CH       = 3,
    parameter int          MODE_W     = 2,
    parameter logic [3:0]  IDLE_CODE  = 4'd0,
    parameter int          GAP_CYCLES = 16,
    parameter int          TIMEOUT    = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MODE_W-1:0]   mode_req,
    input  logic                trig_in,
    output logic [N_CH-1:0]     ch_trig,
    output logic [N_CH-1:0]     ch_en,
    input  logic [N_CH-1:0]     ch_sda_o,
    input  logic [N_CH-1:0]     ch_sda_t,
    input  logic [N_CH-1:0]     ch_scl_t,
    output logic [N_CH-1:0]     ch_sda_i,
    input  logic [N_CH-1:0]     ch_done_send_data,
    input  logic [N_CH-1:0]     ch_done_init,
    input  logic [4*N_CH-1:0]   ch_state_i2c,
    output logic                sda_o,
    output logic                sda_t,
    output logic                scl_t,
    input  logic                sda_i,
    output logic                done_send_data,
    output logic                done_init,
    output logic [3:0]          state_i2c,
    output logic [MODE_W-1:0]   active_mode,
    output logic                busy,
    output logic                abort_pulse
);

    typedef enum logic [1:0] {ACTIVE, DRAIN, GAP, START} state_t;

    localparam logic [N_CH-1:0]  ONE      = {{(N_CH-1){1'b0}}, 1'b1};
    localparam logic [MODE_W:0]  N_LIM    = (MODE_W+1)'(N_CH);
    localparam logic [31:0]      GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT - 1);

    state_t              state, state_next;
    logic [MODE_W-1:0]   active, active_next, target, target_next;
    logic [31:0]         gap_cnt, gap_next, to_cnt, to_next;
    logic                abort_next;
    logic                req_ok, bus_idle, in_gap;
    logic [N_CH-1:0]     sel;

    assign req_ok   = {1'b0, mode_req} < N_LIM;
    assign sel      = ONE << active;
    assign in_gap   = state == GAP;
    assign bus_idle = ch_state_i2c[{active, 2'b00} +: 4] == IDLE_CODE && ch_scl_t[active] && ch_sda_t[active];

    // Output mux: owner drives the pins except during the guard gap, where the bus is forced released
    always_comb begin
        sda_o          = in_gap | ch_sda_o[active];
        sda_t          = in_gap | ch_sda_t[active];
        scl_t          = in_gap | ch_scl_t[active];
        done_send_data = !in_gap && ch_done_send_data[active];
        done_init      = !in_gap && ch_done_init[active];
        state_i2c      = in_gap ? IDLE_CODE : ch_state_i2c[{active, 2'b00} +: 4];
        ch_trig        = (state == START || (state == ACTIVE && trig_in)) ? sel : '0;
        ch_sda_i       = sda_i ? '1 : ~sel;
        busy           = state != ACTIVE;
        active_mode    = active;
    end

    // Next-state: drain the owner's transfer, release the bus for a gap, then redraw on the new owner
    always_comb begin
        state_next  = state;
        active_next = active;
        target_next = target;
        gap_next    = gap_cnt;
        to_next     = to_cnt;
        abort_next  = 1'b0;
        case (state)
            ACTIVE: if (req_ok && mode_req != active) begin
                target_next = mode_req;
                state_next  = DRAIN;
                to_next     = '0;
            end
            DRAIN: begin
                if (req_ok) target_next = mode_req;
                if (req_ok && mode_req == active) begin
                    state_next = ACTIVE;
                end else if (bus_idle) begin
                    state_next = GAP;
                    gap_next   = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_next = GAP;
                    gap_next   = '0;
                    abort_next = 1'b1;
                end else begin
                    to_next = to_cnt + 32'd1;
                end
            end
            GAP: if (gap_cnt == GAP_LAST) begin
                state_next  = START;
                active_next = target;
            end else begin
                gap_next = gap_cnt + 32'd1;
            end
            default: state_next = ACTIVE;
        endcase
    end

    // State register; enable is precomputed from next state so it is never multi-hot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ACTIVE;
            active      <= '0;
            target      <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            ch_en       <= ONE;
            abort_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            active      <= active_next;
            target      <= target_next;
            gap_cnt     <= gap_next;
            to_cnt      <= to_next;
            ch_en       <= (state_next == GAP) ? '0 : ONE << active_next;
            abort_pulse <= abort_next;
        end
    end

endmodule

// File: tb/tb_oled_mode_switcher.sv
// tb_oled_mode_switcher: directed checks of ownership switching, gap, redraw, revert, timeout and reset
module tb_oled_mode_switcher;

    logic        clk, rst, trig_in, sda_i;
    logic [1:0]  mode_req;
    logic [2:0]  ch_trig, ch_en, ch_sda_o, ch_sda_t, ch_scl_t, ch_sda_i, ch_done_send_data, ch_done_init;
    logic [11:0] ch_state_i2c;
    logic        sda_o, sda_t, scl_t, done_send_data, done_init, busy, abort_pulse;
    logic [3:0]  state_i2c;
    logic [1:0]  active_mode;
    int          n_checks = 0;
    int          n_fail = 0;

    oled_mode_switcher #(.N_CH(3), .MODE_W(2), .IDLE_CODE(4'd0), .GAP_CYCLES(16), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .mode_req(mode_req), .trig_in(trig_in), .ch_trig(ch_trig), .ch_en(ch_en),
        .ch_sda_o(ch_sda_o), .ch_sda_t(ch_sda_t), .ch_scl_t(ch_scl_t), .ch_sda_i(ch_sda_i),
        .ch_done_send_data(ch_done_send_data), .ch_done_init(ch_done_init), .ch_state_i2c(ch_state_i2c),
        .sda_o(sda_o), .sda_t(sda_t), .scl_t(scl_t), .sda_i(sda_i), .done_send_data(done_send_data),
        .done_init(done_init), .state_i2c(state_i2c), .active_mode(active_mode), .busy(busy),
        .abort_pulse(abort_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        rst = 1'b0; mode_req = 2'd0; trig_in = 1'b0; sda_i = 1'b1;
        ch_sda_o = 3'b111; ch_sda_t = 3'b111; ch_scl_t = 3'b111;
        ch_done_send_data = 3'b000; ch_done_init = 3'b000; ch_state_i2c = 12'h000;
        #23;
        check("rst_en", 32'(ch_en), 32'h1);
        check("rst_lines", 32'({sda_t, scl_t}), 32'h3);
        check("rst_mode", 32'(active_mode), 32'h0);
        check("rst_busy", 32'({busy, abort_pulse}), 32'h0);
        rst = 1'b1;
        step(1);
        trig_in = 1'b1; #1;
        check("trig_route0", 32'(ch_trig), 32'h1);
        trig_in = 1'b0; #1;
        check("trig_low", 32'(ch_trig), 32'h0);
        ch_sda_o = 3'b110; sda_i = 1'b0; ch_done_send_data = 3'b101; ch_done_init = 3'b011; #1;
        check("mux_sda_o", 32'(sda_o), 32'h0);
        check("sda_readback", 32'(ch_sda_i), 32'h6);
        check("mux_done", 32'({done_send_data, done_init}), 32'h3);
        sda_i = 1'b1;
        // idle switch 0 -> 2, trigger in the request cycle still goes to channel 0
        step(1);
        mode_req = 2'd2; trig_in = 1'b1; #1;
        check("trig_old_owner", 32'(ch_trig), 32'h1);
        step(1);
        check("drain_busy", 32'(busy), 32'h1);
        check("drain_trig_blocked", 32'(ch_trig), 32'h0);
        check("drain_en", 32'(ch_en), 32'h1);
        trig_in = 1'b0;
        step(1);
        ch_state_i2c = 12'h007; ch_done_send_data = 3'b111; ch_done_init = 3'b111; #1;
        for (int i = 0; i < 16; i++) begin
            check("gap_bus", 32'({ch_en, sda_o, sda_t, scl_t, done_send_data, done_init, state_i2c}), 32'({3'b000, 5'b11100, 4'd0}));
            step(1);
        end
        check("start_trig", 32'(ch_trig), 32'h4);
        check("start_en", 32'(ch_en), 32'h4);
        check("start_mode", 32'({active_mode, busy}), 32'({2'd2, 1'b1}));
        ch_state_i2c = 12'h000;
        step(1);
        check("active2", 32'({busy, ch_trig}), 32'h0);
        // mid-transfer switch 2 -> 1
        ch_state_i2c = 12'h300; ch_sda_t = 3'b011; mode_req = 2'd1;
        step(1);
        for (int i = 0; i < 40; i++) begin
            check("drain_hold", 32'({ch_en, sda_t, state_i2c}), 32'({3'b100, 1'b0, 4'd3}));
            step(1);
        end
        ch_state_i2c = 12'h000; ch_sda_t = 3'b111; #1;
        check("drain_last", 32'({busy, ch_en}), 32'({1'b1, 3'b100}));
        step(1);
        check("gap_after_idle", 32'({ch_en, sda_t, busy}), 32'({3'b000, 1'b1, 1'b1}));
        step(16);
        check("start1_trig", 32'(ch_trig), 32'h2);
        check("start1_mode", 32'(active_mode), 32'h1);
        step(1);
        check("active1", 32'(busy), 32'h0);
        // revert during drain
        ch_state_i2c = 12'h030; mode_req = 2'd0;
        step(1);
        check("revert_drain", 32'(busy), 32'h1);
        mode_req = 2'd1;
        step(1);
        check("revert_back", 32'({busy, active_mode, ch_en, ch_trig}), 32'({1'b0, 2'd1, 3'b010, 3'b000}));
        step(1);
        check("revert_no_redraw", 32'({busy, ch_trig}), 32'h0);
        // timeout with channel 1 stuck busy
        mode_req = 2'd0;
        step(1);
        n = 0;
        while (!abort_pulse && n < 200) begin
            step(1);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd100);
        check("timeout_gap", 32'({busy, ch_en}), 32'({1'b1, 3'b000}));
        step(1);
        check("abort_one_cycle", 32'(abort_pulse), 32'h0);
        step(15);
        check("timeout_start", 32'({ch_trig, active_mode}), 32'({3'b001, 2'd0}));
        ch_state_i2c = 12'h000;
        step(1);
        check("timeout_active", 32'(busy), 32'h0);
        // invalid request ignored
        mode_req = 2'd3;
        step(3);
        check("invalid_ignored", 32'({busy, active_mode, ch_en}), 32'({1'b0, 2'd0, 3'b001}));
        // asynchronous reset in the middle of a gap
        mode_req = 2'd2;
        step(7);
        check("pre_rst_gap", 32'({busy, ch_en}), 32'({1'b1, 3'b000}));
        rst = 1'b0; #1;
        check("async_rst", 32'({busy, ch_en, active_mode, sda_t, abort_pulse}), 32'({1'b0, 3'b001, 2'd0, 1'b1, 1'b0}));
        mode_req = 2'd0;
        step(2);
        rst = 1'b1;
        step(2);
        check("post_rst", 32'({busy, ch_en, active_mode}), 32'({1'b0, 3'b001, 2'd0}));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
